ysyx_24110015_ifu: RTL and testbench
====================================

YSYX_24110015_IFU -- requirements
Module: ysyx_24110015_ifu

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have ports `clk` (input, 1): the single clock; all state updates on the rising edge.
REQ-003 SHALL have port `rst` (input, 1): synchronous, active-high reset.
REQ-004 SHALL have ports `araddr` (output, 32), `arvalid` (output, 1) and `arready` (input, 1): the instruction-memory read-address channel.
REQ-005 SHALL have ports `rdata` (input, 32), `rresp` (input, 2), `rvalid` (input, 1) and `rready` (output, 1): the instruction-memory read-data channel.
REQ-006 SHALL have ports `inst` (output, 32) and `pc_o` (output, 32): the instruction and its PC, delivered to decode.
REQ-007 SHALL have ports `out_valid` (output, 1) and `out_ready` (input, 1): the handshake toward decode.
REQ-008 SHALL have port `ifault` (output, 1): the fetch-access-fault flag, qualified by `out_valid`.
REQ-009 SHALL have ports `npc_valid` (input, 1) and `dnpc` (input, 32): the next-PC strobe from write-back, which retires the current instruction.

Function
REQ-010 SHALL implement a four-state FSM: S_AR → S_R → S_OUT → S_NPC → S_AR.
REQ-011 In S_AR, SHALL assert `arvalid` with `araddr` = `pc`, and move to S_R on `arvalid && arready`.
REQ-012 SHALL keep `araddr` stable while `arvalid` is high and unaccepted.
REQ-013 In S_R, SHALL assert `rready`; on `rvalid`, SHALL capture `rdata` into `inst`, set `ifault` = (`rresp` != 0), and move to S_OUT.
REQ-014 On a fault, SHALL force `inst` to 32'h0000_0000.
REQ-015 In S_OUT, SHALL assert `out_valid`, hold `inst`, `pc_o` and `ifault` stable, and move to S_NPC on `out_valid && out_ready`.
REQ-016 In S_NPC, SHALL deassert `out_valid`, `arvalid` and `rready`; on `npc_valid`, SHALL load `pc` ← `dnpc` and move to S_AR.
REQ-017 `pc_o` SHALL always equal the PC register.
REQ-018 `dnpc` SHALL be used as given; no alignment check is applied in this block.
REQ-019 `npc_valid` SHALL be ignored in every state other than S_NPC.
REQ-020 `rvalid` SHALL be ignored outside S_R.
REQ-021 `arvalid` and `rready` SHALL never both be high in the same cycle.
REQ-022 `out_valid` SHALL be high only in S_OUT.
REQ-023 Best-case latency SHALL be: cycle 0 S_AR with `arready`=1; cycle 1 S_R with `rvalid`=1; cycle 2 `out_valid`=1.
REQ-024 Same-cycle arrival of `arready` and a stale `rvalid` in S_AR SHALL be handled by acting on `arready` only.
REQ-025 At most one outstanding read SHALL be issued; no prefetch.
REQ-026 A PC arithmetic wrap from 32'hFFFF_FFFC to `dnpc` SHALL be taken verbatim.

Reset
REQ-027 On `rst`=1 at a clock edge: state ← S_AR, `pc` ← RESET_PC, `inst` ← 0, `ifault` ← 0.
REQ-028 Reset SHALL take priority over every other event, including an in-flight `rvalid` or `npc_valid` in the same cycle.
REQ-029 During reset and the first cycle after it, the outputs SHALL be: `arvalid`=1 (from the cycle after reset deasserts), `rready`=0 and `out_valid`=0.
REQ-030 Reset mid-transaction SHALL abandon the outstanding read; a late `rvalid` arriving in S_AR SHALL be dropped.

Structure
REQ-031 The FSM state encodings and RESET_PC default SHALL live in the shared macros header alongside the opcode/ALU defines.
REQ-032 The `rresp` OKAY encoding (2'b00) SHALL be a shared constant.
REQ-033 One sub-module SHALL be instantiated: ysyx_24110015_Reg, a width-parameterised register with synchronous reset value, used for the PC.
REQ-034 All other logic SHALL be inline.

Verification
REQ-035 Reset release with `arready`=`rvalid`=1 and `rdata`=32'h0010_0093 SHALL give: `araddr`=32'h8000_0000 in cycle 0, `out_valid`=1 in cycle 2 with `inst`=32'h0010_0093, `pc_o`=32'h8000_0000 and `ifault`=0.
REQ-036 With `arready` held low 3 cycles, SHALL see `arvalid` high and `araddr` constant through those 3 cycles, and the read accepted in cycle 4.
REQ-037 With `out_ready`=0 for 5 cycles, SHALL see `out_valid`, `inst` and `pc_o` stable for all 5; after `out_ready`=1 then `npc_valid` with `dnpc`=32'h8000_0010, the next `araddr` SHALL be 32'h8000_0010.
REQ-038 With `rresp`=2'b10 and `rdata`=32'hDEAD_BEEF, SHALL see `ifault`=1 and `inst`=32'h0000_0000 at `out_valid`.
REQ-039 `npc_valid` pulsed in S_R with `dnpc`=32'h1234 SHALL leave the PC unchanged; a second pulse in S_NPC SHALL update it.
REQ-040 `rst` asserted in S_R, followed by `rvalid` 1 cycle after release, SHALL give state S_AR, `araddr`=RESET_PC, and no `out_valid`.

Source files
------------

// File: rtl/ysyx_24110015_ifu_pkg.sv
// Shared IFU constants: FSM encodings, reset PC, read-response codes.
package ysyx_24110015_ifu_pkg;

  typedef enum logic [1:0] {
    S_AR  = 2'd0,
    S_R   = 2'd1,
    S_OUT = 2'd2,
    S_NPC = 2'd3
  } ifu_state_e;

  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
  localparam logic [1:0]  RRESP_OKAY   = 2'b00;
  // Instruction word handed to decode when the fetch faulted.
  localparam logic [31:0] INST_FAULT   = 32'h0000_0000;

  function automatic logic resp_is_fault(input logic [1:0] resp);
    return resp != RRESP_OKAY;
  endfunction

endpackage

// File: rtl/ysyx_24110015_Reg.sv
// Width-parameterised register with synchronous reset value and write enable.
module ysyx_24110015_Reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             wen,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] dout_q;

  // Hold value unless written; reset wins over a write.
  always_ff @(posedge clk) begin
    if (rst)      dout_q <= RESET_VAL;
    else if (wen) dout_q <= din;
  end

  assign dout = dout_q;

endmodule

// File: rtl/ysyx_24110015_ifu.sv
// Instruction fetch unit: one outstanding read per instruction,
// AR -> R -> OUT -> NPC, PC advanced only by the write-back strobe.
module ysyx_24110015_ifu
  import ysyx_24110015_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  // read-address channel
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  // read-data channel
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  // toward decode
  output logic [31:0] inst,
  output logic [31:0] pc_o,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        ifault,
  // next-PC from write-back
  input  logic        npc_valid,
  input  logic [31:0] dnpc
);

  ifu_state_e  state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic        ifault_q, ifault_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] pc_q;
  logic        pc_wen;
  logic        fault;

  ysyx_24110015_Reg #(
    .WIDTH    (32),
    .RESET_VAL(RESET_PC)
  ) u_pc (
    .clk (clk),
    .rst (rst),
    .din (dnpc),
    .wen (pc_wen),
    .dout(pc_q)
  );

  assign fault = resp_is_fault(rresp);

  // Next-state / capture logic; each input is only looked at in its own state,
  // so stale rvalid or early npc_valid fall through untouched.
  always_comb begin
    state_d  = state_q;
    inst_d   = inst_q;
    ifault_d = ifault_q;
    pc_wen   = 1'b0;
    case (state_q)
      S_AR:  if (arready) state_d = S_R;
      S_R:   if (rvalid) begin
               state_d  = S_OUT;
               ifault_d = fault;
               inst_d   = fault ? INST_FAULT : rdata;
             end
      S_OUT: if (out_ready) state_d = S_NPC;
      S_NPC: if (npc_valid) begin
               state_d = S_AR;
               pc_wen  = 1'b1;
             end
      default: state_d = S_AR;
    endcase
    // Handshake outputs are registered off the next state.
    arvalid_d   = (state_d == S_AR);
    rready_d    = (state_d == S_R);
    out_valid_d = (state_d == S_OUT);
  end

  // FSM state, captured instruction and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_AR;
      inst_q      <= '0;
      ifault_q    <= 1'b0;
      arvalid_q   <= 1'b1;
      rready_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      inst_q      <= inst_d;
      ifault_q    <= ifault_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign araddr    = pc_q;
  assign pc_o      = pc_q;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;
  assign out_valid = out_valid_q;
  assign inst      = inst_q;
  assign ifault    = ifault_q;

endmodule

// File: tb/tb_ysyx_24110015_ifu.sv
// Scoreboard bench for the IFU: stimulus pushes expected AR addresses and
// decode-side triples; a negedge monitor pops them on each handshake.
module tb_ysyx_24110015_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  logic [31:0] inst, pc_o;
  logic        out_valid, out_ready, ifault;
  logic        npc_valid;
  logic [31:0] dnpc;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_ar[$];
  logic [64:0] exp_out[$];   // {ifault, pc, inst}

  typedef struct {
    int          arw, rw, ow;
    bit          noise;
    logic [31:0] rd;
    logic [1:0]  resp;
    logic [31:0] einst;
    logic        efault;
    logic [31:0] pc, npc;
  } vec_t;

  vec_t vecs[7];

  ysyx_24110015_ifu #(.RESET_PC(32'h8000_0000)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .inst(inst), .pc_o(pc_o), .out_valid(out_valid), .out_ready(out_ready),
    .ifault(ifault), .npc_valid(npc_valid), .dnpc(dnpc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: handshakes and the AR/R exclusivity rule, sampled at negedge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("ar_r_excl", {31'b0, arvalid & rready}, 32'd0);
        if (arvalid && arready) begin
          if (exp_ar.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL ar_unexpected: got araddr %h expected no request", araddr);
          end else chk("araddr", araddr, exp_ar.pop_front());
        end
        if (out_valid && out_ready) begin
          if (exp_out.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL out_unexpected: got inst %h expected no output", inst);
          end else begin
            logic [64:0] e;
            e = exp_out.pop_front();
            chk("out_inst", inst, e[31:0]);
            chk("out_pc", pc_o, e[63:32]);
            chk("out_fault", {31'b0, ifault}, {31'b0, e[64]});
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // One full fetch; DUT must be in S_AR on entry.
  task automatic fetch(input vec_t v);
    exp_ar.push_back(v.pc);
    exp_out.push_back({v.efault, v.pc, v.einst});
    // address phase, optionally with stale rvalid traffic
    arready = 1'b0;
    for (int i = 0; i < v.arw; i++) begin
      if (v.noise) begin rvalid = 1'b1; rdata = 32'hBAD0_BAD0; rresp = 2'b11; end
      chk("ar_wait_valid", {31'b0, arvalid}, 32'd1);
      chk("ar_wait_addr", araddr, v.pc);
      chk("ar_wait_rready", {31'b0, rready}, 32'd0);
      tick;
    end
    arready = 1'b1;
    if (v.noise) begin rvalid = 1'b1; rdata = 32'hBAD0_BAD0; rresp = 2'b11; end
    chk("ar_acc_valid", {31'b0, arvalid}, 32'd1);
    tick;
    arready = 1'b0; rvalid = 1'b0;
    // data phase, optionally with ignored npc_valid pulses
    chk("r_rready", {31'b0, rready}, 32'd1);
    chk("r_arvalid", {31'b0, arvalid}, 32'd0);
    for (int i = 0; i < v.rw; i++) begin
      if (v.noise) begin npc_valid = 1'b1; dnpc = 32'h0000_1234; end
      tick;
      npc_valid = 1'b0;
      chk("r_wait_pc", pc_o, v.pc);
    end
    rvalid = 1'b1; rdata = v.rd; rresp = v.resp;
    tick;
    rvalid = 1'b0; rdata = 32'h5555_AAAA; rresp = 2'b00;
    chk("out_latency", {31'b0, out_valid}, 32'd1);
    // output phase, decode stalls for ow cycles
    for (int i = 0; i < v.ow; i++) begin
      if (v.noise) begin npc_valid = 1'b1; dnpc = 32'h0000_1234; end
      chk("out_hold_valid", {31'b0, out_valid}, 32'd1);
      chk("out_hold_inst", inst, v.einst);
      chk("out_hold_pc", pc_o, v.pc);
      tick;
      npc_valid = 1'b0;
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("npc_quiet", {29'b0, out_valid, arvalid, rready}, 32'd0);
    npc_valid = 1'b1; dnpc = v.npc;
    tick;
    npc_valid = 1'b0; dnpc = 32'h0;
    chk("npc_arvalid", {31'b0, arvalid}, 32'd1);
    chk("npc_araddr", araddr, v.npc);
  endtask

  initial begin
    //            arw rw ow noise rdata          resp   exp inst       flt pc             dnpc
    vecs[0] = '{0, 0, 0, 1'b0, 32'h0010_0093, 2'b00, 32'h0010_0093, 1'b0, 32'h8000_0000, 32'h8000_0004};
    vecs[1] = '{3, 1, 0, 1'b1, 32'h0000_0513, 2'b00, 32'h0000_0513, 1'b0, 32'h8000_0004, 32'h8000_0008};
    vecs[2] = '{0, 0, 5, 1'b0, 32'h00A0_0593, 2'b00, 32'h00A0_0593, 1'b0, 32'h8000_0008, 32'h8000_0010};
    vecs[3] = '{1, 0, 0, 1'b0, 32'hDEAD_BEEF, 2'b10, 32'h0000_0000, 1'b1, 32'h8000_0010, 32'hFFFF_FFFC};
    vecs[4] = '{0, 2, 1, 1'b1, 32'h1234_5678, 2'b01, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[5] = '{0, 0, 0, 1'b0, 32'hCAFE_F00D, 2'b00, 32'hCAFE_F00D, 1'b0, 32'h0000_0000, 32'h8000_0002};
    vecs[6] = '{0, 0, 2, 1'b0, 32'h0000_8067, 2'b11, 32'h0000_0000, 1'b1, 32'h8000_0002, 32'h8000_0040};

    // reset held while every other input is active
    rst = 1'b1; arready = 1'b1; rvalid = 1'b1; rdata = 32'hFFFF_FFFF; rresp = 2'b00;
    out_ready = 1'b1; npc_valid = 1'b1; dnpc = 32'h0000_1234;
    tick; tick;
    chk("rst_arvalid", {31'b0, arvalid}, 32'd1);
    chk("rst_rready", {31'b0, rready}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_pc", pc_o, 32'h8000_0000);
    chk("rst_inst", inst, 32'h0);
    chk("rst_ifault", {31'b0, ifault}, 32'd0);
    rst = 1'b0; arready = 1'b0; rvalid = 1'b0; out_ready = 1'b0; npc_valid = 1'b0; dnpc = 32'h0;

    for (int i = 0; i < 7; i++) fetch(vecs[i]);

    // reset in S_R with rvalid/npc_valid in the same cycle, then a late rvalid
    exp_ar.push_back(32'h8000_0040);
    arready = 1'b1;
    tick;
    arready = 1'b0;
    chk("abort_in_r", {31'b0, rready}, 32'd1);
    rst = 1'b1; rvalid = 1'b1; rdata = 32'hBAAD_F00D; npc_valid = 1'b1; dnpc = 32'h0000_1234;
    tick;
    chk("abort_araddr", araddr, 32'h8000_0000);
    chk("abort_quiet", {30'b0, rready, out_valid}, 32'd0);
    rst = 1'b0; rvalid = 1'b0; npc_valid = 1'b0;
    tick;
    rvalid = 1'b1; rdata = 32'hBAAD_F00D; rresp = 2'b00;
    tick;
    rvalid = 1'b0;
    chk("late_r_arvalid", {31'b0, arvalid}, 32'd1);
    chk("late_r_araddr", araddr, 32'h8000_0000);
    chk("late_r_out", {31'b0, out_valid}, 32'd0);
    chk("late_r_inst", inst, 32'h0);
    tick;
    chk("late_r_out2", {30'b0, out_valid, rready}, 32'd0);

    fetch(vecs[0]);

    tick; tick;
    chk("ar_queue_empty", exp_ar.size(), 32'd0);
    chk("out_queue_empty", exp_out.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
